// File: rtl/led_pattern_slave.sv
// led_pattern_slave: accepts 2-bit LED-mode codes over valid/ready, queues them
// in a small circular FIFO and plays each one on the LED for a fixed dwell time.
// Codes: 0 = off, 1 = slow blink, 2 = fast blink, 3 = on.
module led_pattern_slave #(
  parameter int DEPTH     = 4,
  parameter int BASE_HALF = 1_000_000,
  parameter int DWELL     = 50_000_000,
  parameter int CNT_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inValid,
  input  logic [1:0]              dataIn,
  output logic                    ready,
  output logic                    led,
  output logic [1:0]              ledMode,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [LW-1:0]    FULL_LEVEL = LW'(DEPTH);
  localparam logic [CNT_W-1:0] FAST_LAST  = CNT_W'(BASE_HALF - 1);
  localparam logic [CNT_W-1:0] SLOW_LAST  = CNT_W'(4 * BASE_HALF - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [1:0]       fifo_mem [DEPTH];
  logic [AW-1:0]    head_reg;
  logic [AW-1:0]    tail_reg;
  logic [LW-1:0]    level_reg;
  logic [CNT_W-1:0] dwell_reg;
  logic [CNT_W-1:0] phase_reg;
  logic             led_reg;
  logic [1:0]       mode_reg;
  logic             busy_reg;

  logic             push;
  logic             pop;
  logic [CNT_W-1:0] half_last;

  // Ready depends on registered occupancy only, so a pop never frees a slot
  // for a push in the same cycle.
  assign ready     = !rst && (level_reg != FULL_LEVEL);
  assign push      = inValid && ready;
  assign pop       = (state_reg == LOAD);
  assign half_last = (mode_reg == 2'd1) ? SLOW_LAST : FAST_LAST;

  assign led     = led_reg;
  assign ledMode = mode_reg;
  assign busy    = busy_reg;
  assign level   = level_reg;

  // FIFO storage: write-only port here, read is registered by the FSM in LOAD.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[tail_reg] <= dataIn;
    end
  end

  // FIFO pointers and occupancy; push and pop in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      level_reg <= '0;
    end else begin
      if (push) begin
        tail_reg <= tail_reg + AW'(1);
      end
      if (pop) begin
        head_reg <= head_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Playback FSM: loads a code, then plays it for at least DWELL cycles,
  // reloading only when another code is waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      led_reg   <= 1'b0;
      mode_reg  <= 2'd0;
      busy_reg  <= 1'b0;
      dwell_reg <= '0;
      phase_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          led_reg  <= 1'b0;
          mode_reg <= 2'd0;
          busy_reg <= 1'b0;
          if (level_reg != '0) begin
            state_reg <= LOAD;
            busy_reg  <= 1'b1;
          end
        end
        LOAD: begin
          // Blink codes start in the on phase; only code 0 starts dark.
          mode_reg  <= fifo_mem[head_reg];
          led_reg   <= (fifo_mem[head_reg] != 2'd0);
          dwell_reg <= '0;
          phase_reg <= '0;
          busy_reg  <= 1'b1;
          state_reg <= RUN;
        end
        RUN: begin
          busy_reg <= 1'b1;
          if (mode_reg == 2'd1 || mode_reg == 2'd2) begin
            if (phase_reg == half_last) begin
              led_reg   <= ~led_reg;
              phase_reg <= '0;
            end else begin
              phase_reg <= phase_reg + CNT_W'(1);
            end
          end
          // Dwell saturates at its last value, so a code arriving late is
          // loaded on the very next cycle.
          if (dwell_reg == DWELL_LAST) begin
            if (level_reg != '0) begin
              state_reg <= LOAD;
            end
          end else begin
            dwell_reg <= dwell_reg + CNT_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_slave.sv
// Directed testbench for led_pattern_slave with DEPTH=4, BASE_HALF=4, DWELL=40.
// Times are tracked as edge counts; outputs are sampled 1 time unit after an edge.
module tb_led_pattern_slave;

  logic       clk;
  logic       rst;
  logic       inValid;
  logic [1:0] dataIn;
  logic       ready;
  logic       led;
  logic [1:0] ledMode;
  logic       busy;
  logic [2:0] level;

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;

  led_pattern_slave #(
    .DEPTH     (4),
    .BASE_HALF (4),
    .DWELL     (40),
    .CNT_W     (32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .inValid (inValid),
    .dataIn  (dataIn),
    .ready   (ready),
    .led     (led),
    .ledMode (ledMode),
    .busy    (busy),
    .level   (level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Advance n rising edges, leaving time 1 unit after the last edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  task automatic goto(input int t);
    if (t > cyc) step(t - cyc);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    inValid = 1'b0;
    step(1);
    rst = 1'b0;
  endtask

  int e;
  int l;
  logic [1:0] seq [4];

  initial begin
    rst     = 1'b1;
    inValid = 1'b1;
    dataIn  = 2'd3;
    seq[0] = 2'd1; seq[1] = 2'd3; seq[2] = 2'd0; seq[3] = 2'd2;

    // ---- Reset held 3 cycles with inValid high
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("rst_ready", ready, 0);
      chk("rst_level", level, 0);
      chk("rst_led", led, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mode", ledMode, 0);
    end
    rst     = 1'b0;
    inValid = 1'b0;
    step(1);
    chk("post_rst_ready", ready, 1);
    chk("post_rst_level", level, 0);

    // ---- Fast blink: code 2 pushed at edge e
    e = cyc + 1;
    inValid = 1'b1; dataIn = 2'd2;
    step(1);
    inValid = 1'b0;
    chk("fb_level_e", level, 1);
    chk("fb_mode_e", ledMode, 0);
    chk("fb_busy_e", busy, 0);
    goto(e + 1);
    chk("fb_mode_e1", ledMode, 0);
    goto(e + 2);
    chk("fb_mode_e2", ledMode, 2);
    chk("fb_led_e2", led, 1);
    chk("fb_level_e2", level, 0);
    chk("fb_busy_e2", busy, 1);
    goto(e + 5);  chk("fb_led_n3", led, 1);
    goto(e + 6);  chk("fb_led_n4", led, 0);
    goto(e + 10); chk("fb_led_n8", led, 1);
    goto(e + 46); chk("fb_led_n44", led, 0);
    goto(e + 50);
    chk("fb_led_n48", led, 1);
    chk("fb_mode_n48", ledMode, 2);

    // ---- Ordering and spacing: 1,3,0,2 back-to-back
    do_reset();
    e = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      inValid = 1'b1; dataIn = seq[i];
      step(1);
    end
    inValid = 1'b0;
    l = e + 2;
    chk("ord_level_e3", level, 3);
    chk("ord_mode_e3", ledMode, 1);
    goto(l + 15); chk("ord_slow_n15", led, 1);
    goto(l + 16); chk("ord_slow_n16", led, 0);
    goto(l + 32); chk("ord_slow_n32", led, 1);
    goto(l + 40);
    chk("ord_mode_before_2nd", ledMode, 1);
    goto(l + 41);
    chk("ord_mode_2nd", ledMode, 3);
    chk("ord_led_2nd", led, 1);
    chk("ord_level_2nd", level, 2);
    goto(l + 61); chk("ord_on_hold", led, 1);
    goto(l + 82);
    chk("ord_mode_3rd", ledMode, 0);
    chk("ord_led_3rd", led, 0);
    chk("ord_level_3rd", level, 1);
    goto(l + 102); chk("ord_off_hold", led, 0);
    goto(l + 123);
    chk("ord_mode_4th", ledMode, 2);
    chk("ord_led_4th", led, 1);
    chk("ord_level_4th", level, 0);

    // ---- Full FIFO while code 3 plays, then simultaneous push/pop
    do_reset();
    e = cyc + 1;
    inValid = 1'b1; dataIn = 2'd3;
    step(1);
    inValid = 1'b0;
    l = e + 2;
    goto(l + 2);
    inValid = 1'b1; dataIn = 2'd0; step(1);
    dataIn = 2'd1; step(1);
    dataIn = 2'd2; step(1);
    dataIn = 2'd0; step(1);
    chk("full_level", level, 4);
    chk("full_ready", ready, 0);
    dataIn = 2'd3;  // held with inValid high; must not be captured
    goto(l + 20);
    chk("full_level_hold", level, 4);
    chk("full_ready_hold", ready, 0);
    chk("full_mode_hold", ledMode, 3);
    chk("full_led_hold", led, 1);
    goto(l + 40);
    chk("full_ready_in_load", ready, 0);
    goto(l + 41);
    chk("full_level_after_load", level, 3);
    chk("full_ready_after_load", ready, 1);
    chk("full_mode_after_load", ledMode, 0);
    chk("full_led_after_load", led, 0);
    inValid = 1'b0;
    goto(l + 82);
    chk("full_mode_q2", ledMode, 1);
    chk("full_level_q2", level, 2);
    goto(l + 122);
    chk("sim_level_pre", level, 2);
    inValid = 1'b1; dataIn = 2'd3;
    step(1);
    inValid = 1'b0;
    chk("sim_level_post", level, 2);
    chk("sim_mode_post", ledMode, 2);
    chk("sim_led_post", led, 1);
    goto(l + 164);
    chk("sim_mode_q4", ledMode, 0);
    chk("sim_level_q4", level, 1);
    goto(l + 205);
    chk("sim_mode_last", ledMode, 3);
    chk("sim_led_last", led, 1);
    chk("sim_level_last", level, 0);
    goto(l + 250);
    chk("sim_mode_stay", ledMode, 3);
    chk("sim_level_stay", level, 0);

    // ---- Reset mid-blink with level 3, then fresh code 1
    do_reset();
    e = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      inValid = 1'b1; dataIn = seq[i];
      step(1);
    end
    inValid = 1'b0;
    l = e + 2;
    goto(l + 10);
    chk("mid_level_pre", level, 3);
    chk("mid_mode_pre", ledMode, 1);
    chk("mid_led_pre", led, 1);
    rst = 1'b1;
    step(1);
    chk("mid_led_rst", led, 0);
    chk("mid_level_rst", level, 0);
    chk("mid_mode_rst", ledMode, 0);
    chk("mid_busy_rst", busy, 0);
    chk("mid_ready_rst", ready, 0);
    rst = 1'b0;
    step(3);
    chk("mid_busy_idle", busy, 0);
    chk("mid_mode_idle", ledMode, 0);
    chk("mid_level_idle", level, 0);
    e = cyc + 1;
    inValid = 1'b1; dataIn = 2'd1;
    step(1);
    inValid = 1'b0;
    goto(e + 1);
    chk("mid_new_mode_e1", ledMode, 0);
    goto(e + 2);
    chk("mid_new_mode_e2", ledMode, 1);
    chk("mid_new_led_e2", led, 1);
    chk("mid_new_busy_e2", busy, 1);
    goto(e + 18);
    chk("mid_new_led_n16", led, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
